// File: rtl/demux_1to2_buffered.sv
// demux_1to2_buffered: steers one word stream into two independently
// buffered valid/ready output channels, chosen per word by in_sel.
// Each channel owns a small FIFO so a stalled consumer only back-pressures
// words headed its own way.

// Per-channel FIFO: explicit occupancy counter, wrapping pointers,
// storage cleared on reset so the head reads 0 while empty after reset.
module demux_1to2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  // Next pointers and occupancy; push+pop together leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write at the write pointer; wiped on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
endmodule

module demux_1to2_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [$clog2(DEPTH):0] count0,
  output logic [$clog2(DEPTH):0] count1
);
  localparam int NCH = 2;
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [NCH-1:0]            push, pop, full, valid, ready;
  logic [NCH-1:0][WIDTH-1:0] rdata;
  logic [NCH-1:0][CW-1:0]    count;

  // in_ready looks only at the selected FIFO's full flag, never at pops,
  // so there is no path from out*_ready back to the producer.
  assign in_ready = !full[in_sel];
  assign ready    = {out1_ready, out0_ready};

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      assign push[g] = in_valid && in_ready && (in_sel == 1'(g));
      assign pop[g]  = valid[g] && ready[g];

      demux_1to2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push[g]),
        .pop_i   (pop[g]),
        .wdata_i (in_data),
        .rdata_o (rdata[g]),
        .valid_o (valid[g]),
        .full_o  (full[g]),
        .count_o (count[g])
      );
    end
  endgenerate

  assign out0_data  = rdata[0];
  assign out0_valid = valid[0];
  assign count0     = count[0];
  assign out1_data  = rdata[1];
  assign out1_valid = valid[1];
  assign count1     = count[1];
endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed bench for demux_1to2_buffered (WIDTH=32, DEPTH=2).
module tb_demux_1to2_buffered;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_sel, in_valid, in_ready;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [1:0]  count0, count1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  demux_1to2_buffered #(.WIDTH(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .count0     (count0),
    .count1     (count1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [31:0] d);
    in_sel = sel; in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_d0", out0_data, 0);
    chk("rst_c1", count1, 0);
    chk("rst_rdy", in_ready, 1);

    // Single word to out0, popped the cycle after it appears.
    out0_ready = 1'b1;
    push(1'b0, 32'hDEADBEEF);
    chk("s1_v0", out0_valid, 1);
    chk("s1_d0", out0_data, 32'hDEADBEEF);
    chk("s1_v1", out1_valid, 0);
    chk("s1_c0", count0, 1);
    tick();
    chk("s1_c0_pop", count0, 0);
    chk("s1_v0_pop", out0_valid, 0);

    // Fill FIFO 1 with out1 stalled; out0 stays usable.
    out0_ready = 1'b0; out1_ready = 1'b0;
    push(1'b1, 32'h11);
    push(1'b1, 32'h22);
    chk("s2_c1", count1, 2);
    in_sel = 1'b1; #1;
    chk("s2_rdy_sel1", in_ready, 0);
    in_sel = 1'b0; #1;
    chk("s2_rdy_sel0", in_ready, 1);
    push(1'b0, 32'h33);
    chk("s2_d0", out0_data, 32'h33);
    chk("s2_c0", count0, 1);
    out0_ready = 1'b1;
    tick();
    chk("s2_c0_pop", count0, 0);
    out0_ready = 1'b0;

    // Full FIFO 1 with consumer now ready: 0x44 must wait one cycle.
    out1_ready = 1'b1; in_sel = 1'b1; in_data = 32'h44; in_valid = 1'b1;
    #1;
    chk("s3_rdy_full", in_ready, 0);
    chk("s3_head0", out1_data, 32'h11);
    tick();
    chk("s3_rdy", in_ready, 1);
    chk("s3_head1", out1_data, 32'h22);
    chk("s3_c1a", count1, 1);
    tick();
    in_valid = 1'b0;
    chk("s3_head2", out1_data, 32'h44);
    chk("s3_c1b", count1, 1);
    tick();
    chk("s3_c1_empty", count1, 0);

    // Same-cycle push and pop on FIFO 1 holding one word.
    out1_ready = 1'b0;
    push(1'b1, 32'h55);
    out1_ready = 1'b1;
    push(1'b1, 32'h66);
    chk("s5_c1", count1, 1);
    chk("s5_head", out1_data, 32'h66);
    tick();
    chk("s5_drain", count1, 0);

    // 100-word alternating stream with both consumers ready.
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_sel = i[0]; in_data = 32'h1000 + i; in_valid = 1'b1;
      #1;
      chk("s4_rdy", in_ready, 1);
      tick();
      chk("s4_data", (i[0] ? out1_data : out0_data), 32'h1000 + i);
      chk("s4_valid", (i[0] ? out1_valid : out0_valid), 1);
      chk("s4_cnt", (count0 <= 2'd1) && (count1 <= 2'd1), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("s4_end_c0", count0, 0);
    chk("s4_end_c1", count1, 0);

    // Fill both FIFOs, then reset for one cycle.
    out0_ready = 1'b0; out1_ready = 1'b0;
    push(1'b0, 32'hA0); push(1'b0, 32'hA1);
    push(1'b1, 32'hB0); push(1'b1, 32'hB1);
    chk("s6_c0_full", count0, 2);
    chk("s6_c1_full", count1, 2);
    out0_ready = 1'b1; out1_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("s6_c0", count0, 0);
    chk("s6_c1", count1, 0);
    chk("s6_v0", out0_valid, 0);
    chk("s6_v1", out1_valid, 0);
    chk("s6_d0", out0_data, 0);
    chk("s6_d1", out1_data, 0);
    in_sel = 1'b1; #1;
    chk("s6_rdy", in_ready, 1);
    out0_ready = 1'b1;
    push(1'b0, 32'hDEADBEEF);
    chk("s6_post_d0", out0_data, 32'hDEADBEEF);
    chk("s6_post_v0", out0_valid, 1);
    chk("s6_post_v1", out1_valid, 0);
    tick();
    chk("s6_post_c0", count0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
